// File: rtl/pcx_req_arb.sv
// pcx_req_arb: round-robin, credit-gated arbiter sharing one PCX destination port, with CAS1/CAS2 atomic lock.
// Latency: req_gnt is combinational; the granted packet appears on pcx_vld/pcx_data/pcx_src one cycle later.
// Backpressure: no grant without a credit (two for an atomic head); requesters hold req_vld until granted.
// Optional PCX_ARB_STALL_STATS_EN builds a saturating stall counter; otherwise stall_cnt is tied to zero.
module pcx_req_arb #(
    parameter int NREQ      = 4,
    parameter int PCX_WIDTH = 124,
    parameter int CREDITS   = 2,
    parameter int SRC_W     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_vld,
    input  logic [NREQ-1:0]           req_atom,
    input  logic [NREQ*PCX_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]           req_gnt,
    input  logic                      pcx_credit_ret,
    output logic                      pcx_vld,
    output logic [PCX_WIDTH-1:0]      pcx_data,
    output logic [SRC_W-1:0]          pcx_src,
    output logic [2:0]                credit_cnt,
    output logic                      credit_ovf,
    output logic [31:0]               stall_cnt
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t               state;
    logic [SRC_W-1:0]     rr_ptr;
    logic [SRC_W-1:0]     lock_id;
    logic [SRC_W-1:0]     gnt_idx;
    logic                 gnt_any;
    logic                 gnt_atom;
    logic [NREQ-1:0]      elig;
    logic                 lock_vld;
    logic [PCX_WIDTH-1:0] sel_data;

    // Modulo-NREQ wrap for a scan position that is at most 2*NREQ-2.
    function automatic int wrap(input int v);
        return (v >= NREQ) ? v - NREQ : v;
    endfunction

    // Per-requester eligibility: an atomic head needs room for both halves.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_vld[i] && (req_atom[i] ? (credit_cnt >= 3'd2) : (credit_cnt != 3'd0));
        end
    end

    // Pending status of the locked requester, decoded without a variable bit-select.
    always_comb begin
        lock_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (lock_id == SRC_W'(i)) begin
                lock_vld = req_vld[i];
            end
        end
    end

    // Grant selection: locked requester only in LOCK, otherwise first eligible from rr_ptr.
    always_comb begin
        req_gnt = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (!rst) begin
            if (state == LOCK) begin
                if (lock_vld && (credit_cnt != 3'd0)) begin
                    gnt_any = 1'b1;
                    gnt_idx = lock_id;
                    for (int i = 0; i < NREQ; i++) begin
                        if (lock_id == SRC_W'(i)) begin
                            req_gnt[i] = 1'b1;
                        end
                    end
                end
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (!gnt_any && elig[i] && (wrap(int'(rr_ptr) + k) == i)) begin
                            gnt_any    = 1'b1;
                            gnt_idx    = SRC_W'(i);
                            req_gnt[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Granted packet mux and whether it opens an atomic pair.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_gnt[i]) begin
                sel_data = req_data[i*PCX_WIDTH +: PCX_WIDTH];
            end
        end
        gnt_atom = |(req_atom & req_gnt);
    end

    // Arbitration FSM: advance rr_ptr on IDLE grants, hold the lock across the second atomic packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_id <= '0;
        end else if (gnt_any) begin
            if (state == IDLE) begin
                rr_ptr <= (gnt_idx == SRC_W'(NREQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
                if (gnt_atom) begin
                    state   <= LOCK;
                    lock_id <= gnt_idx;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

    // Output register: capture the granted packet and its source index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcx_vld  <= 1'b0;
            pcx_data <= '0;
            pcx_src  <= '0;
        end else begin
            pcx_vld <= gnt_any;
            if (gnt_any) begin
                pcx_data <= sel_data;
                pcx_src  <= gnt_idx;
            end
        end
    end

    // Credit counter: a grant consumes, a return refills; a return while full sets the sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_cnt <= 3'(CREDITS);
            credit_ovf <= 1'b0;
        end else if (gnt_any && !pcx_credit_ret) begin
            credit_cnt <= credit_cnt - 3'd1;
        end else if (!gnt_any && pcx_credit_ret) begin
            if (credit_cnt == 3'(CREDITS)) begin
                credit_ovf <= 1'b1;
            end else begin
                credit_cnt <= credit_cnt + 3'd1;
            end
        end
    end

`ifdef PCX_ARB_STALL_STATS_EN
    // Stall statistics: cycles with a pending request but no grant, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((|req_vld) && !gnt_any && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pcx_req_arb.sv
// tb_pcx_req_arb: directed checks of pcx_req_arb with NREQ=4, CREDITS=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-2 units after it.
// Stall expectations depend on whether PCX_ARB_STALL_STATS_EN is defined for the build.
module tb_pcx_req_arb;
    localparam int NREQ = 4;
    localparam int PW   = 124;
    localparam int SW   = 3;
`ifdef PCX_ARB_STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_vld;
    logic [NREQ-1:0]    req_atom;
    logic [NREQ*PW-1:0] req_data;
    logic [NREQ-1:0]    req_gnt;
    logic               pcx_credit_ret;
    logic               pcx_vld;
    logic [PW-1:0]      pcx_data;
    logic [SW-1:0]      pcx_src;
    logic [2:0]         credit_cnt;
    logic               credit_ovf;
    logic [31:0]        stall_cnt;

    int total  = 0;
    int passed = 0;

    pcx_req_arb #(.NREQ(NREQ), .PCX_WIDTH(PW), .CREDITS(2), .SRC_W(SW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_vld        (req_vld),
        .req_atom       (req_atom),
        .req_data       (req_data),
        .req_gnt        (req_gnt),
        .pcx_credit_ret (pcx_credit_ret),
        .pcx_vld        (pcx_vld),
        .pcx_data       (pcx_data),
        .pcx_src        (pcx_src),
        .credit_cnt     (credit_cnt),
        .credit_ovf     (credit_ovf),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pkt(input int i, input int n);
        return {8'(n), 108'd0, 8'(i)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input int i, input int n);
        req_data[i*PW +: PW] = pkt(i, n);
    endtask

    initial begin
        rst = 1'b1;
        req_vld = '0;
        req_atom = '0;
        req_data = '0;
        pcx_credit_ret = 1'b0;
        for (int i = 0; i < NREQ; i++) set_pkt(i, 0);

        // Reset state, with requests present while rst is high.
        cyc();
        req_vld = 4'b1111;
        #1;
        chk("rst_gnt", req_gnt, 4'b0000);
        chk("rst_vld", pcx_vld, 1'b0);
        chk("rst_data", pcx_data, '0);
        chk("rst_src", pcx_src, 3'd0);
        chk("rst_cnt", credit_cnt, 3'd2);
        chk("rst_ovf", credit_ovf, 1'b0);
        chk("rst_stall", stall_cnt, 32'd0);
        cyc();
        rst = 1'b0;

        // Fairness: all requesting, credit returned from the second grant onward.
        for (int k = 0; k < 6; k++) begin
            pcx_credit_ret = (k >= 1);
            #1;
            chk("rr_gnt", req_gnt, 4'b0001 << (k % 4));
            cyc();
            chk("rr_vld", pcx_vld, 1'b1);
            chk("rr_src", pcx_src, 3'(k % 4));
            chk("rr_data", pcx_data, pkt(k % 4, 0));
            chk("rr_cnt", credit_cnt, 3'd1);
        end

        // Idle return refills; a return while full sets the sticky overflow.
        req_vld = '0;
        pcx_credit_ret = 1'b1;
        cyc();
        chk("idle_vld", pcx_vld, 1'b0);
        chk("refill_cnt", credit_cnt, 3'd2);
        chk("refill_ovf", credit_ovf, 1'b0);
        cyc();
        chk("ovf_cnt", credit_cnt, 3'd2);
        chk("ovf_set", credit_ovf, 1'b1);
        pcx_credit_ret = 1'b0;
        cyc();
        chk("ovf_sticky", credit_ovf, 1'b1);

        // Credit exhaustion on requester 2 (rr_ptr is 2 here).
        req_vld = 4'b0100;
        #1;
        chk("ex_gnt1", req_gnt, 4'b0100);
        cyc();
        chk("ex_cnt1", credit_cnt, 3'd1);
        chk("ex_gnt2", req_gnt, 4'b0100);
        cyc();
        chk("ex_cnt0", credit_cnt, 3'd0);
        chk("ex_src", pcx_src, 3'd2);
        chk("ex_gnt0a", req_gnt, 4'b0000);
        cyc();
        chk("ex_novld", pcx_vld, 1'b0);
        chk("ex_gnt0b", req_gnt, 4'b0000);
        cyc();
        pcx_credit_ret = 1'b1;
        #1;
        chk("ex_ret_nognt", req_gnt, 4'b0000);
        cyc();
        pcx_credit_ret = 1'b0;
        chk("ex_cnt_ret", credit_cnt, 3'd1);
        #1;
        chk("ex_gnt3", req_gnt, 4'b0100);
        cyc();
        req_vld = '0;
        chk("ex_vld3", pcx_vld, 1'b1);
        chk("ex_cnt_end", credit_cnt, 3'd0);
        chk("ex_stall", stall_cnt, STATS ? 32'd3 : 32'd0);
        pcx_credit_ret = 1'b1;
        cyc();
        cyc();
        pcx_credit_ret = 1'b0;
        chk("ex_restore", credit_cnt, 3'd2);

        // Grant plus return at full credits leaves the count at 2; moves rr_ptr to 1.
        req_vld = 4'b0001;
        pcx_credit_ret = 1'b1;
        #1;
        chk("gr_gnt", req_gnt, 4'b0001);
        cyc();
        chk("gr_cnt", credit_cnt, 3'd2);
        chk("gr_ovf", credit_ovf, 1'b1);

        // Atomic lock: requester 1 atomic, 0 and 3 also pending.
        pcx_credit_ret = 1'b0;
        req_vld = 4'b1011;
        req_atom = 4'b0010;
        #1;
        chk("at_gnt1", req_gnt, 4'b0010);
        cyc();
        chk("at_src1", pcx_src, 3'd1);
        chk("at_cnt1", credit_cnt, 3'd1);
        set_pkt(1, 1);
        #1;
        chk("at_gnt2", req_gnt, 4'b0010);
        cyc();
        chk("at_data2", pcx_data, pkt(1, 1));
        chk("at_cnt2", credit_cnt, 3'd0);
        req_vld = 4'b1001;
        req_atom = '0;
        pcx_credit_ret = 1'b1;
        #1;
        chk("at_gnt_none", req_gnt, 4'b0000);
        cyc();
        pcx_credit_ret = 1'b0;
        #1;
        chk("at_next3", req_gnt, 4'b1000);
        cyc();
        chk("at_src3", pcx_src, 3'd3);
        req_vld = '0;
        pcx_credit_ret = 1'b1;
        cyc();
        pcx_credit_ret = 1'b0;
        chk("ag_cnt1", credit_cnt, 3'd1);

        // Atomic gating at one credit (rr_ptr is 0).
        req_vld = 4'b0011;
        req_atom = 4'b0001;
        #1;
        chk("ag_gnt1", req_gnt, 4'b0010);
        cyc();
        req_vld = 4'b0001;
        pcx_credit_ret = 1'b1;
        #1;
        chk("ag_wait0", req_gnt, 4'b0000);
        cyc();
        #1;
        chk("ag_wait1", req_gnt, 4'b0000);
        cyc();
        pcx_credit_ret = 1'b0;
        chk("ag_cnt2", credit_cnt, 3'd2);
        #1;
        chk("ag_gnt0", req_gnt, 4'b0001);
        cyc();
        chk("ag_src0", pcx_src, 3'd0);

        // Reset in the middle of the locked pair.
        req_vld = 4'b1111;
        req_atom = '0;
        #1;
        rst = 1'b1;
        #1;
        chk("mr_gnt", req_gnt, 4'b0000);
        chk("mr_vld", pcx_vld, 1'b0);
        chk("mr_cnt", credit_cnt, 3'd2);
        chk("mr_ovf", credit_ovf, 1'b0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mr_first0", req_gnt, 4'b0001);
        cyc();
        chk("mr_src0", pcx_src, 3'd0);
        chk("mr_next1", req_gnt, 4'b0010);
        cyc();
        chk("mr_src1", pcx_src, 3'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
